// File: rtl/mem_access_stage.sv
// mem_access_stage: memory pipeline stage.
// Consumes the execute/memory register outputs and runs a load/store
// handshake against a variable-latency data-memory port. Upstream is
// stalled until the access completes. Results go out as a registered
// write-back bundle.
// Optional feature: define MEM_TIMEOUT_EN to enable a WAIT-state watchdog.
// The watchdog aborts an access that has not been acknowledged within
// TIMEOUT_CYCLES cycles and reports it with a one-cycle bus_err pulse.
module mem_access_stage #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_dst,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              out_valid,
  output logic              out_reg_write,
  output logic [REG_W-1:0]  out_dst,
  output logic [DATA_W-1:0] out_wdata,
  output logic              misalign,
  output logic              bus_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t              state_r;
  logic                dmem_req_r;
  logic                dmem_we_r;
  logic [DATA_W-1:0]   dmem_addr_r;
  logic [DATA_W-1:0]   dmem_wdata_r;
  logic [REG_W-1:0]    dst_r;
  logic                reg_write_r;
  logic                out_valid_r;
  logic                out_reg_write_r;
  logic [REG_W-1:0]    out_dst_r;
  logic [DATA_W-1:0]   out_wdata_r;
  logic                misalign_r;
  logic                bus_err_r;
  logic                stall_s;
  logic                mem_op_s;
  logic                aligned_s;
  logic                timeout_s;

  assign mem_op_s  = in_mem_read | in_mem_write;
  assign aligned_s = (in_addr[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_r;

  // Count WAIT cycles; the count reaches TIMEOUT_CYCLES on the edge that leaves WAIT by timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_r == WAIT) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == WAIT) && (wait_cnt_r == TO_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Stall upstream while an aligned access is being issued or is still outstanding.
  always_comb begin
    stall_s = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && mem_op_s && aligned_s) stall_s = 1'b1;
          else stall_s = 1'b0;
        end
        WAIT: begin
          if (dmem_ack || timeout_s) stall_s = 1'b0;
          else stall_s = 1'b1;
        end
        default: stall_s = 1'b0;
      endcase
    end
  end

  // Access FSM with the registered memory port and write-back bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      dmem_req_r      <= 1'b0;
      dmem_we_r       <= 1'b0;
      dmem_addr_r     <= '0;
      dmem_wdata_r    <= '0;
      dst_r           <= '0;
      reg_write_r     <= 1'b0;
      out_valid_r     <= 1'b0;
      out_reg_write_r <= 1'b0;
      out_dst_r       <= '0;
      out_wdata_r     <= '0;
      misalign_r      <= 1'b0;
      bus_err_r       <= 1'b0;
    end else begin
      // The bundle is a one-cycle pulse unless a completion below overrides it.
      out_valid_r     <= 1'b0;
      out_reg_write_r <= 1'b0;
      out_dst_r       <= '0;
      out_wdata_r     <= '0;
      misalign_r      <= 1'b0;
      bus_err_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!in_valid) begin
            state_r <= IDLE;
          end else if (!mem_op_s) begin
            out_valid_r     <= 1'b1;
            out_reg_write_r <= in_reg_write;
            out_dst_r       <= in_dst;
            out_wdata_r     <= in_addr;
          end else if (!aligned_s) begin
            // Misaligned accesses are dropped without touching memory.
            out_valid_r <= 1'b1;
            out_dst_r   <= in_dst;
            misalign_r  <= 1'b1;
          end else begin
            // read and write together are treated as a load.
            state_r      <= WAIT;
            dmem_req_r   <= 1'b1;
            dmem_we_r    <= in_mem_write & ~in_mem_read;
            dmem_addr_r  <= in_addr;
            dmem_wdata_r <= in_store_data;
            dst_r        <= in_dst;
            reg_write_r  <= in_reg_write;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state_r     <= IDLE;
            dmem_req_r  <= 1'b0;
            out_valid_r <= 1'b1;
            out_dst_r   <= dst_r;
            if (!dmem_we_r) begin
              out_reg_write_r <= reg_write_r;
              out_wdata_r     <= dmem_rdata;
            end else begin
              out_reg_write_r <= 1'b0;
              out_wdata_r     <= '0;
            end
          end else if (timeout_s) begin
            state_r     <= IDLE;
            dmem_req_r  <= 1'b0;
            out_valid_r <= 1'b1;
            out_dst_r   <= dst_r;
            bus_err_r   <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          state_r    <= IDLE;
          dmem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign stall         = stall_s;
  assign dmem_req      = dmem_req_r;
  assign dmem_we       = dmem_we_r;
  assign dmem_addr     = dmem_addr_r;
  assign dmem_wdata    = dmem_wdata_r;
  assign out_valid     = out_valid_r;
  assign out_reg_write = out_reg_write_r;
  assign out_dst       = out_dst_r;
  assign out_wdata     = out_wdata_r;
  assign misalign      = misalign_r;
  assign bus_err       = bus_err_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mem_read, in_mem_write, in_reg_write;
  logic [31:0] in_addr, in_store_data;
  logic [4:0]  in_dst;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        out_valid, out_reg_write, misalign, bus_err;
  logic [4:0]  out_dst;
  logic [31:0] out_wdata;

  int checks   = 0;
  int failures = 0;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_addr(in_addr), .in_store_data(in_store_data),
    .in_dst(in_dst), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_reg_write(out_reg_write), .out_dst(out_dst),
    .out_wdata(out_wdata), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic rw,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst);
    in_valid = v; in_mem_read = rd; in_mem_write = wr; in_reg_write = rw;
    in_addr = a; in_store_data = d; in_dst = dst;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick; tick;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_dmem_req got=%0h exp=0", dmem_req); end
    checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || out_wdata !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", dmem_addr, dmem_wdata, out_wdata); end
    checks++; if (stall !== 1'b0 || misalign !== 1'b0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%0h%0h%0h exp=000", stall, misalign, bus_err); end
    rst = 1'b0;
  endtask

  task automatic test_alu_passthrough;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 5'd7);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%0h exp=0", stall); end
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checks++; if (out_valid !== 1'b1 || out_reg_write !== 1'b1) begin
      failures++; $display("FAIL alu_valid got=%0h/%0h exp=1/1", out_valid, out_reg_write); end
    checks++; if (out_dst !== 5'd7 || out_wdata !== 32'h0000_1234) begin
      failures++; $display("FAIL alu_data got=%0d/%h exp=7/00001234", out_dst, out_wdata); end
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL alu_no_req got=%0h exp=0", dmem_req); end
    tick;
    checks++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || out_wdata !== 32'h0 || out_dst !== 5'd0) begin
      failures++; $display("FAIL bubble_out got=%0h/%0h/%h/%0d exp=0/0/0/0", out_valid, out_reg_write, out_wdata, out_dst); end
  endtask

  task automatic test_load;
    int stall_hi = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd3);
    #1;
    if (stall === 1'b1) stall_hi++;
    tick;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h0000_0100) begin
      failures++; $display("FAIL load_req got=%0h/%0h/%h exp=1/0/00000100", dmem_req, dmem_we, dmem_addr); end
    // Upstream garbage during WAIT must be ignored.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h5555_5555, 5'd9);
    #1;
    if (stall === 1'b1) stall_hi++;
    tick;
    #1;
    if (stall === 1'b1) stall_hi++;
    checks++; if (dmem_addr !== 32'h0000_0100 || dmem_we !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL load_hold got=%h/%0h/%0h exp=00000100/0/0", dmem_addr, dmem_we, out_valid); end
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    if (stall === 1'b1) stall_hi++;
    checks++; if (stall_hi !== 3) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=3", stall_hi); end
    tick;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    checks++; if (out_valid !== 1'b1 || out_reg_write !== 1'b1 || out_dst !== 5'd3) begin
      failures++; $display("FAIL load_wb got=%0h/%0h/%0d exp=1/1/3", out_valid, out_reg_write, out_dst); end
    checks++; if (out_wdata !== 32'hDEAD_BEEF || dmem_req !== 1'b0) begin
      failures++; $display("FAIL load_data got=%h/%0h exp=deadbeef/0", out_wdata, dmem_req); end
    tick;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL load_one_shot got=%0h exp=0", out_valid); end
  endtask

  task automatic test_store;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_CAFE, 5'd4);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL store_stall_issue got=%0h exp=1", stall); end
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h0000_CAFE || dmem_addr !== 32'h0000_0200) begin
      failures++; $display("FAIL store_req got=%0h/%0h/%h/%h exp=1/1/0000cafe/00000200", dmem_req, dmem_we, dmem_wdata, dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_stall_ack got=%0h exp=0", stall); end
    tick;
    dmem_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || out_wdata !== 32'h0 || out_dst !== 5'd4) begin
      failures++; $display("FAIL store_wb got=%0h/%0h/%h/%0d exp=1/0/0/4", out_valid, out_reg_write, out_wdata, out_dst); end
    tick;
  endtask

  task automatic test_misalign;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 5'd5);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL misalign_stall got=%0h exp=0", stall); end
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checks++; if (misalign !== 1'b1 || out_valid !== 1'b1 || out_reg_write !== 1'b0 || dmem_req !== 1'b0) begin
      failures++; $display("FAIL misalign_pulse got=%0h/%0h/%0h/%0h exp=1/1/0/0", misalign, out_valid, out_reg_write, dmem_req); end
    tick;
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL misalign_one_shot got=%0h exp=0", misalign); end
  endtask

  task automatic test_ack_idle;
    dmem_ack = 1'b1; dmem_rdata = 32'hABCD_0000;
    tick;
    dmem_ack = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_wdata !== 32'h0 || dmem_req !== 1'b0) begin
      failures++; $display("FAIL ack_idle got=%0h/%h/%0h exp=0/0/0", out_valid, out_wdata, dmem_req); end
  endtask

  task automatic test_back_to_back;
    // Load with read and write both set, acked at minimum latency, then an ALU op right behind it.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h7777_7777, 5'd10);
    tick;
    checks++; if (dmem_we !== 1'b0 || dmem_req !== 1'b1) begin
      failures++; $display("FAIL rw_as_load got=%0h/%0h exp=0/1", dmem_we, dmem_req); end
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    tick;
    dmem_ack = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0099, 32'h0, 5'd11);
    checks++; if (out_valid !== 1'b1 || out_dst !== 5'd10 || out_wdata !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL b2b_load got=%0h/%0d/%h exp=1/10/0badf00d", out_valid, out_dst, out_wdata); end
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checks++; if (out_valid !== 1'b1 || out_dst !== 5'd11 || out_wdata !== 32'h0000_0099) begin
      failures++; $display("FAIL b2b_alu got=%0h/%0d/%h exp=1/11/00000099", out_valid, out_dst, out_wdata); end
    tick;
  endtask

  task automatic test_reset_mid_access;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 5'd6);
    tick;
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL midrst_req got=%0h exp=1", dmem_req); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL midrst_drop got=%0h/%0h exp=0/0", dmem_req, stall); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick;
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick;
    dmem_ack = 1'b0;
    checks++; if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
      failures++; $display("FAIL midrst_no_wb got=%0h/%0h exp=0/0", out_valid, dmem_req); end
    tick;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_wb2 got=%0h exp=0", out_valid); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int stall_hi = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 5'd8);
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (stall === 1'b1) stall_hi++;
      if (i < 3) tick;
    end
    checks++; if (stall_hi !== 3 || dmem_req !== 1'b1) begin
      failures++; $display("FAIL timeout_wait got=%0d/%0h exp=3/1", stall_hi, dmem_req); end
    tick;
    checks++; if (bus_err !== 1'b1 || out_valid !== 1'b1 || out_reg_write !== 1'b0 || dmem_req !== 1'b0) begin
      failures++; $display("FAIL timeout_abort got=%0h/%0h/%0h/%0h exp=1/1/0/0", bus_err, out_valid, out_reg_write, dmem_req); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 32'h0, 5'd2);
    tick;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    checks++; if (bus_err !== 1'b0 || out_valid !== 1'b1 || out_wdata !== 32'h0000_0055) begin
      failures++; $display("FAIL timeout_recover got=%0h/%0h/%h exp=0/1/00000055", bus_err, out_valid, out_wdata); end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_alu_passthrough;
    test_load;
    test_store;
    test_misalign;
    test_ack_idle;
    test_back_to_back;
`ifdef MEM_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid_access;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
